// File: rtl/boot_rom_arb_pkg.sv
// =============================================================================
// boot_rom_arb_pkg : shared constants and helpers for the boot ROM arbiter
// Revision: 1.0
// =============================================================================
`default_nettype none

package boot_rom_arb_pkg;

   localparam logic [31:0] BOOT_ROM_ERR_DATA   = 32'h0;
   localparam int          BOOT_ROM_MAX_MASTER = 4;
   localparam int          BOOT_ROM_IDX_W      = $clog2(BOOT_ROM_MAX_MASTER);

   typedef logic [BOOT_ROM_IDX_W-1:0] master_idx_t;

   // Round-robin successor of a master index, wrapping at n.
   function automatic master_idx_t next_ptr(input master_idx_t idx, input int n);
      return (int'(idx) + 1 >= n) ? '0 : master_idx_t'(int'(idx) + 1);
   endfunction

endpackage

`default_nettype wire

// File: rtl/boot_rom_arbiter_if.sv
// =============================================================================
// boot_rom_arbiter_if : master-side request/response bus of the boot ROM arbiter
// Revision: 1.0
// =============================================================================
`default_nettype none

interface boot_rom_arbiter_if #(
   parameter int N_MASTER = 2
);
   logic [N_MASTER-1:0]        req_i;
   logic [N_MASTER-1:0][31:0]  add_i;
   logic [N_MASTER-1:0]        wen_i;
   logic [N_MASTER-1:0]        gnt_o;
   logic [N_MASTER-1:0]        r_valid_o;
   logic [31:0]                r_rdata_o;
   logic                       r_opc_o;

   modport master (
      output req_i, add_i, wen_i,
      input  gnt_o, r_valid_o, r_rdata_o, r_opc_o
   );

   modport slave (
      input  req_i, add_i, wen_i,
      output gnt_o, r_valid_o, r_rdata_o, r_opc_o
   );
endinterface

`default_nettype wire

// File: rtl/boot_rom_rr_arb.sv
// =============================================================================
// boot_rom_rr_arb : round-robin selector, first requester at or after pointer
// Revision: 1.0
// =============================================================================
`default_nettype none

module boot_rom_rr_arb
   import boot_rom_arb_pkg::*;
#(
   parameter int N_MASTER = 2
) (
   input  logic [N_MASTER-1:0] req,
   input  master_idx_t         pointer,
   output logic [N_MASTER-1:0] grant,
   output master_idx_t         index
);

   logic w_found;

   // First pass covers indices at/after the pointer, second pass wraps to 0.
   always_comb begin
      grant   = '0;
      index   = '0;
      w_found = 1'b0;
      for (int i = 0; i < N_MASTER; i++) begin
         if (!w_found && req[i] && (i >= int'(pointer))) begin
            grant[i] = 1'b1;
            index    = master_idx_t'(i);
            w_found  = 1'b1;
         end
      end
      for (int i = 0; i < N_MASTER; i++) begin
         if (!w_found && req[i]) begin
            grant[i] = 1'b1;
            index    = master_idx_t'(i);
            w_found  = 1'b1;
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/boot_rom_arbiter.sv
// =============================================================================
// boot_rom_arbiter : round-robin shared boot ROM port, 1 access/cycle, latency 1
// Optional macro BOOT_ROM_LOCK_EN adds lock_i and a sticky lock flag.
// Revision: 1.0
// =============================================================================
`default_nettype none

module boot_rom_arbiter
   import boot_rom_arb_pkg::*;
#(
   parameter int ROM_ADDR_WIDTH = 13,
   parameter int N_MASTER       = 2
) (
   input  logic                      clk_i,
   input  logic                      rst_ni,
`ifdef BOOT_ROM_LOCK_EN
   input  logic                      lock_i,
`endif
   boot_rom_arbiter_if.slave         bus,
   output logic                      rom_csn_o,
   output logic [ROM_ADDR_WIDTH-3:0] rom_add_o,
   input  logic [31:0]               rom_rdata_i
);

   logic [N_MASTER-1:0]       w_req;
   logic [N_MASTER-1:0]       w_gnt;
   master_idx_t               w_idx;
   logic                      w_any;
   logic [31:0]               w_add;
   logic                      w_is_write;
   logic                      w_lock_err;
   logic                      w_err;
   logic                      w_rom_acc;
   logic                      w_resp;
   logic                      w_unused;

   master_idx_t               r_ptr;
   logic [N_MASTER-1:0]       r_valid;
   logic                      r_err;
   logic [ROM_ADDR_WIDTH-3:0] r_rom_add;

   // Nothing is granted while reset is held, so the ROM stays deselected.
   assign w_req = bus.req_i & {N_MASTER{rst_ni}};
   assign w_any = |w_req;

   boot_rom_rr_arb #(
      .N_MASTER (N_MASTER)
   ) u_rr_arb (
      .req     (w_req),
      .pointer (r_ptr),
      .grant   (w_gnt),
      .index   (w_idx)
   );

   always_comb begin
      w_add = '0;
      for (int i = 0; i < N_MASTER; i++) begin
         if (w_gnt[i]) w_add = bus.add_i[i];
      end
   end

   assign w_is_write = |(w_gnt & ~bus.wen_i);
   assign w_unused   = ^{w_add[31:ROM_ADDR_WIDTH], w_add[1:0]};

`ifdef BOOT_ROM_LOCK_EN
   logic r_lock;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni)     r_lock <= 1'b0;
      else if (lock_i) r_lock <= 1'b1;
   end

   // Master 0 keeps ROM access after lock; everyone else gets an error.
   assign w_lock_err = r_lock & ~w_gnt[0];
`else
   assign w_lock_err = 1'b0;
`endif

   assign w_err     = w_is_write | w_lock_err;
   assign w_rom_acc = w_any & ~w_err;

   assign rom_csn_o = ~w_rom_acc;
   assign rom_add_o = w_rom_acc ? w_add[ROM_ADDR_WIDTH-1:2] : r_rom_add;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_ptr     <= '0;
         r_valid   <= '0;
         r_err     <= 1'b0;
         r_rom_add <= '0;
      end else begin
         r_valid <= w_gnt;
         r_err   <= w_any & w_err;
         if (w_any)     r_ptr     <= next_ptr(w_idx, N_MASTER);
         if (w_rom_acc) r_rom_add <= w_add[ROM_ADDR_WIDTH-1:2];
      end
   end

   assign w_resp        = |r_valid;
   assign bus.gnt_o     = w_gnt;
   assign bus.r_valid_o = r_valid;
   assign bus.r_opc_o   = w_resp & r_err;
   assign bus.r_rdata_o = !w_resp ? 32'h0 : (r_err ? BOOT_ROM_ERR_DATA : rom_rdata_i);

endmodule

`default_nettype wire

// File: tb/tb_boot_rom_arbiter.sv
// =============================================================================
// tb_boot_rom_arbiter : directed + randomized bench against a transaction model
// Revision: 1.0
// =============================================================================
`default_nettype none

module tb_boot_rom_arbiter;

   localparam int N     = 2;
   localparam int AW    = 13;
   localparam int WORDS = 1 << (AW - 2);

   logic          clk = 1'b0;
   logic          rst_n;
   logic          rom_csn;
   logic [AW-3:0] rom_add;
   logic [31:0]   rom_rdata;
   logic [31:0]   rom_mem [WORDS];
`ifdef BOOT_ROM_LOCK_EN
   logic          lock_v;
`endif

   int n_checks = 0;
   int n_errors = 0;

   // Transaction-level model state
   int          m_ptr;
   bit          m_pend;
   int          m_pend_idx;
   logic [31:0] m_pend_data;
   bit          m_pend_opc;
   bit          m_locked;

   boot_rom_arbiter_if #(.N_MASTER(N)) bif ();

   boot_rom_arbiter #(
      .ROM_ADDR_WIDTH (AW),
      .N_MASTER       (N)
   ) dut (
      .clk_i       (clk),
      .rst_ni      (rst_n),
`ifdef BOOT_ROM_LOCK_EN
      .lock_i      (lock_v),
`endif
      .bus         (bif),
      .rom_csn_o   (rom_csn),
      .rom_add_o   (rom_add),
      .rom_rdata_i (rom_rdata)
   );

   always #5 clk = ~clk;

   // Synchronous ROM: data one cycle after a selected cycle.
   always @(posedge clk) begin
      if (rom_csn === 1'b0) rom_rdata <= rom_mem[rom_add];
   end

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_ptr    = 0;
      m_pend   = 0;
      m_locked = 0;
   endtask

   // One bus cycle: drive, predict, check at negedge, advance model at posedge.
   task automatic run_cycle(input logic [N-1:0] req, input logic [N-1:0][31:0] add,
                            input logic [N-1:0] wen);
      int            w;
      logic [N-1:0]  e_gnt;
      logic [N-1:0]  e_valid;
      bit            e_err;
      bif.req_i = req;
      bif.add_i = add;
      bif.wen_i = wen;
      w = -1;
      for (int k = 0; k < N; k++) begin
         int j = (m_ptr + k) % N;
         if (w < 0 && req[j]) w = j;
      end
      e_gnt = '0;
      e_err = 0;
      if (w >= 0) begin
         e_gnt[w] = 1'b1;
         e_err    = !wen[w] || (m_locked && w != 0);
      end
      e_valid = '0;
      if (m_pend) e_valid[m_pend_idx] = 1'b1;
      @(negedge clk);
      check_eq("gnt", bif.gnt_o, e_gnt);
      check_eq("rom_csn", rom_csn, (w >= 0 && !e_err) ? 1'b0 : 1'b1);
      if (w >= 0 && !e_err) check_eq("rom_add", rom_add, add[w][AW-1:2]);
      check_eq("r_valid", bif.r_valid_o, e_valid);
      check_eq("r_rdata", bif.r_rdata_o, m_pend ? m_pend_data : 32'h0);
      check_eq("r_opc", bif.r_opc_o, m_pend ? m_pend_opc : 1'b0);
      @(posedge clk);
      m_pend = (w >= 0);
      if (w >= 0) begin
         m_pend_idx  = w;
         m_pend_opc  = e_err;
         m_pend_data = e_err ? 32'h0 : rom_mem[add[w][AW-1:2]];
         m_ptr       = (w + 1) % N;
      end
`ifdef BOOT_ROM_LOCK_EN
      if (lock_v) m_locked = 1;
`endif
      #1;
   endtask

   task automatic idle();
      run_cycle('0, '0, '1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      for (int i = 0; i < WORDS; i++) rom_mem[i] = $urandom;
      rom_mem[0] = 32'h1111_0000;
      rom_mem[1] = 32'hCAFE_0001;
      rom_mem[2] = 32'h2222_0002;
`ifdef BOOT_ROM_LOCK_EN
      lock_v = 1'b0;
`endif
      rom_rdata = '0;

      // Requests asserted during reset must not reach the ROM.
      rst_n     = 1'b0;
      bif.req_i = '1;
      bif.add_i = '{default: 32'h0000_0010};
      bif.wen_i = '1;
      #2;
      check_eq("rst_gnt", bif.gnt_o, '0);
      check_eq("rst_valid", bif.r_valid_o, '0);
      check_eq("rst_opc", bif.r_opc_o, 1'b0);
      check_eq("rst_csn", rom_csn, 1'b1);
      check_eq("rst_add", rom_add, '0);
      check_eq("rst_rdata", bif.r_rdata_o, 32'h0);
      bif.req_i = '0;
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
      @(posedge clk);
      #1;

      // Both masters requesting every cycle: grants alternate from master 0.
      for (int c = 0; c < 6; c++) run_cycle(2'b11, {32'(c * 8 + 4), 32'(c * 8)}, 2'b11);
      idle();

      // Master 0 read of aliased address 0x1A00_0004 -> ROM word 1.
      run_cycle(2'b01, {32'h0, 32'h1A00_0004}, 2'b11);
      check_eq("cafe_valid", bif.r_valid_o, 2'b01);
      check_eq("cafe_rdata", bif.r_rdata_o, 32'hCAFE_0001);
      idle();

      // Master 1 write: no ROM access, error response.
      run_cycle(2'b10, {32'h8, 32'h0}, 2'b01);
      check_eq("wr_valid", bif.r_valid_o, 2'b10);
      check_eq("wr_opc", bif.r_opc_o, 1'b1);
      idle();

      // Back-to-back reads of words 0, 1, 2.
      for (int c = 0; c < 3; c++) run_cycle(2'b01, {32'h0, 32'(c * 4)}, 2'b11);
      idle();

      // Reset right after a grant discards the pending response.
      run_cycle(2'b01, {32'h0, 32'h4}, 2'b11);
      rst_n     = 1'b0;
      bif.req_i = '0;
      @(negedge clk);
      check_eq("rst2_valid", bif.r_valid_o, '0);
      check_eq("rst2_csn", rom_csn, 1'b1);
      check_eq("rst2_rdata", bif.r_rdata_o, 32'h0);
      rst_n = 1'b1;
      model_reset();
      @(posedge clk);
      #1;
      run_cycle(2'b11, {32'h8, 32'h4}, 2'b11);
      idle();

`ifdef BOOT_ROM_LOCK_EN
      lock_v = 1'b1;
      idle();
      lock_v = 1'b0;
      run_cycle(2'b10, {32'h0, 32'h0}, 2'b11);
      check_eq("lock_m1_opc", bif.r_opc_o, 1'b1);
      check_eq("lock_m1_rdata", bif.r_rdata_o, 32'h0);
      run_cycle(2'b01, {32'h0, 32'h0}, 2'b11);
      check_eq("lock_m0_rdata", bif.r_rdata_o, 32'h1111_0000);
      idle();
`endif

      // Randomized traffic with aliased addresses and mixed reads/writes.
      for (int c = 0; c < 400; c++) begin
         logic [N-1:0]       r;
         logic [N-1:0][31:0] a;
         logic [N-1:0]       w;
         r = N'($urandom);
         for (int m = 0; m < N; m++) begin
            a[m] = $urandom;
            w[m] = ($urandom_range(0, 3) != 0);
         end
         run_cycle(r, a, w);
      end
      idle();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

`default_nettype wire
